mem_access: RTL

Memory-stage data-access unit sitting directly upstream of the write-back stage. It takes the load/store decoded in MEM, drives the sram-like data bus (req/addr_ok/data_ok), and raises a pipeline stall until the access completes. It latches the raw 32-bit read word that write-back sign/zero-extends and lane-selects using address bits [1:0]. Misaligned accesses are flagged as address errors and never issued.

---
 rtl/mem_access.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Purpose: MEM-stage load/store unit driving the sram-like data bus (req/addr_ok/data_ok).
// Latency: minimum 2 cycles (issue, data_ok); load word is on mem_rdata the cycle after data_ok.
// Backpressure: holds req until addr_ok, asserts mem_stall until data_ok, parks in DONE while stall_in.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  // MEM stage instruction
  input  logic        m_valid,
  input  logic        m_memread,
  input  logic        m_memwrite,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        flush,
  input  logic        stall_in,
  // data bus
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  // to write-back / hazard logic
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        adel,
  output logic        ades
);

  // Access phases. DONE parks a finished access while something else holds MEM;
  // DRAIN swallows the response of an access that was flushed after issue.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Everything the bus needs to see for one request, presented as one bundle.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        addr_err;
  logic        mem_op;
  logic        start;
  logic        load_q;
  logic [31:0] rdata_q;
  logic [31:0] wdata_lane;
  bus_cmd_t    cmd;

  // Alignment check: halves need addr[0]=0, words (and the illegal size 3) need addr[1:0]=0.
  always_comb begin
    addr_err = 1'b0;
    case (m_size)
      2'd0:    addr_err = 1'b0;
      2'd1:    addr_err = m_addr[0];
      default: addr_err = |m_addr[1:0];
    endcase
  end

  assign mem_op = m_memread | m_memwrite;
  assign adel   = m_valid & m_memread  & addr_err;
  assign ades   = m_valid & m_memwrite & addr_err;

  // A new access may only launch from IDLE; a flush in the same cycle wins.
  assign start = (state == S_IDLE) & m_valid & mem_op & ~addr_err & ~flush;

  // Replicate store data across the lanes the bus will byte-enable from addr/size.
  always_comb begin
    wdata_lane = m_wdata;
    case (m_size)
      2'd0:    wdata_lane = {4{m_wdata[7:0]}};
      2'd1:    wdata_lane = {2{m_wdata[15:0]}};
      default: wdata_lane = m_wdata;
    endcase
  end

  // Bus command is driven straight from the MEM inputs; upstream keeps them stable under mem_stall.
  always_comb begin
    cmd.wr    = m_memwrite;
    cmd.size  = m_size;
    cmd.addr  = m_addr;
    cmd.wdata = wdata_lane;
  end

  assign data_wr    = cmd.wr;
  assign data_size  = cmd.size;
  assign data_addr  = cmd.addr;
  assign data_wdata = cmd.wdata;

  // Request is up on the launch cycle and every following cycle until the bus accepts it.
  assign data_req = start | (state == S_REQ);

  // Stall MEM while the access is outstanding; release in the data_ok cycle and in DONE.
  assign mem_stall = start
                   | (state == S_REQ)
                   | ((state == S_WAIT) & ~data_data_ok)
                   | (state == S_DRAIN);

  // Next-state selection for the single-outstanding access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        // An accept coinciding with a flush still leaves a response in flight.
        if (data_addr_ok) begin
          state_nxt = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (flush)         state_nxt = S_IDLE;
          else if (stall_in) state_nxt = S_DONE;
          else               state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush || !stall_in) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (data_data_ok) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remember whether the in-flight access is a load, fixed at launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q <= 1'b0;
    end else if (start) begin
      load_q <= m_memread;
    end
  end

  // Capture the raw read word on a load's data_ok; drained and store responses leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if ((state == S_WAIT) && data_data_ok && load_q) begin
      rdata_q <= data_rdata;
    end
  end

  assign mem_rdata = rdata_q;

endmodule
